game_rules_engine: RTL
======================

# game_rules_engine

Parametrised game-rule controller for the Pac-Man datapath. Consumes per-step player/ghost positions and dot-consumption events, and owns game state, lives, power-mode timer, combo ghost scoring and dot count. Converts the binary score to BCD for the seven-segment drivers. Sits between the character controllers and the renderer/seven-segment blocks, in the VGA clock domain.

## Interface
- NUM_GHOSTS, 4, number of ghost channels
- COORD_W, 10, coordinate width (x and y)
- TILE_SIZE, 20, collision box half-width in pixels
- MAX_DOTS, 240, dots+big dots needed to win (<2^9)
- POWER_TICKS, 15, power-mode duration in ticks (>=1)
- DEATH_TICKS, 10, post-death freeze in ticks (>=1)
- LIVES, 3, initial lives (1..7)
- DOT_POINTS / BIGDOT_POINTS / GHOST_POINTS, 10 / 50 / 200
- SCORE_W, 20, binary score width; DIGITS, 6, BCD digits (10^DIGITS-1 < 2^SCORE_W)
- clk  in  1  system clock (25 MHz)
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle game-step strobe (character update rate)
- start  in  1  level; high = any movement key pressed
- player_x / player_y  in  COORD_W  player position
- ghost_x / ghost_y  in  NUM_GHOSTS*COORD_W  ghost i at bits [i*COORD_W +: COORD_W]
- dot_hit / bigdot_hit  in  1  player consumed small/big dot this step (valid only with tick)
- game_state  out  3  0 STANDBY, 1 PLAYING, 2 POWER, 3 DYING, 4 GAMEOVER, 5 WIN
- ghost_respawn  out  NUM_GHOSTS  one-clk pulse per ghost to reset to spawn
- life_lost  out  1  one-clk pulse
- lives  out  3  remaining lives
- dots_eaten  out  9  consumed dot count
- power_remaining  out  8  ticks left in POWER, else 0
- score  out  SCORE_W  binary score
- score_bcd  out  4*DIGITS  BCD score, digit 0 in [3:0]

## Operation
- Collision for ghost i: |gx-px| < TILE_SIZE and |gy-py| < TILE_SIZE (unsigned compare after magnitude subtraction); evaluated only on tick.
- STANDBY: start=1 -> PLAYING next clk (no tick needed). All other inputs ignored.
- PLAYING, tick: apply dots first. dot_hit: +DOT_POINTS, dots_eaten+1. bigdot_hit: +BIGDOT_POINTS, dots_eaten+1, enter POWER, power_remaining=POWER_TICKS, combo=0. Both high: both counted (+2).
- Win: if updated dots_eaten >= MAX_DOTS -> WIN; takes priority over any collision same tick.
- PLAYING collision (any ghost, no big dot this tick): lives-1, life_lost pulse, all ghost_respawn bits pulse; lives reaching 0 -> GAMEOVER, else DYING with death counter=DEATH_TICKS.
- POWER, tick: colliding ghosts eaten in ascending index order; k-th eaten since power start scores GHOST_POINTS<<min(k,3) (200,400,800,1600), its ghost_respawn bit pulses. Then power_remaining-1; reaching 0 -> PLAYING. Big dot in POWER reloads POWER_TICKS, combo=0.
- DYING, tick: counter-1; at 0 -> PLAYING. dot/bigdot/collision ignored.
- GAMEOVER, WIN: terminal until reset; all inputs ignored.
- Score saturates at 10^DIGITS-1; all points of one tick summed before saturation.
- BCD: sequential double-dabble, one bit/clk; start when score changes and converter idle; score_bcd updated atomically on completion. Score change during conversion sets pending; reconversion starts on completion (coalesced, latest value).

## Timing
- Reset (async, asserted low): STANDBY, lives=LIVES, score=0, score_bcd=0, dots_eaten=0, power_remaining=0, ghost_respawn=0, life_lost=0, converter idle.
- All outputs registered; state/counters/score change on the clk edge sampling tick=1 (latency 1 clk); pulses high exactly that following cycle.
- score_bcd latency: SCORE_W+2 clks after score change when idle; worst case 2*(SCORE_W+2).
- tick assumed >= SCORE_W+2 clks apart in operation; closer ticks remain correct (coalescing).

## Test plan
- Reset then start=1 -> game_state=1 next clk; lives=3, score_bcd=0.
- PLAYING, tick with dot_hit -> score=10, dots_eaten=1, score_bcd=0x000010 within 22 clks.
- bigdot_hit tick then ghosts 0 and 2 colliding next tick -> +50, then +200+400 (score 650), ghost_respawn=4'b0101 one clk, power_remaining=14.
- PLAYING collision with lives=1 -> life_lost pulse, lives=0, game_state=4; further ticks/start change nothing.
- dots_eaten=MAX_DOTS-1, tick with dot_hit and collision -> game_state=5, lives unchanged.
- Reset asserted mid-BCD conversion and in POWER -> all outputs at reset values immediately, no respawn pulse.

Source files
------------

// File: rtl/game_rules_engine.sv
// Pac-Man rule controller: game state, lives, power timer, ghost combo scoring and dot count,
// plus a one-bit-per-clock binary-to-BCD converter feeding the score display.
module game_rules_engine #(
    parameter int NUM_GHOSTS    = 4,
    parameter int COORD_W       = 10,
    parameter int TILE_SIZE     = 20,
    parameter int MAX_DOTS      = 240,
    parameter int POWER_TICKS   = 15,
    parameter int DEATH_TICKS   = 10,
    parameter int LIVES         = 3,
    parameter int DOT_POINTS    = 10,
    parameter int BIGDOT_POINTS = 50,
    parameter int GHOST_POINTS  = 200,
    parameter int SCORE_W       = 20,
    parameter int DIGITS        = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          start,
    input  logic [COORD_W-1:0]            player_x,
    input  logic [COORD_W-1:0]            player_y,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
    input  logic                          dot_hit,
    input  logic                          bigdot_hit,
    output logic [2:0]                    game_state,
    output logic [NUM_GHOSTS-1:0]         ghost_respawn,
    output logic                          life_lost,
    output logic [2:0]                    lives,
    output logic [8:0]                    dots_eaten,
    output logic [7:0]                    power_remaining,
    output logic [SCORE_W-1:0]            score,
    output logic [4*DIGITS-1:0]           score_bcd
);
    typedef enum logic [2:0] {
        ST_STANDBY  = 3'd0,
        ST_PLAYING  = 3'd1,
        ST_POWER    = 3'd2,
        ST_DYING    = 3'd3,
        ST_GAMEOVER = 3'd4,
        ST_WIN      = 3'd5
    } state_e;

    typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} conv_e;

    localparam int SUM_W = SCORE_W + 8;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [SUM_W-1:0]   MAX_SCORE = SUM_W'(10 ** DIGITS - 1);
    localparam logic [COORD_W-1:0] TILE      = COORD_W'(TILE_SIZE);

    state_e                  state_q, state_d;
    logic [2:0]              lives_q, lives_d;
    logic [8:0]              dots_q, dots_d;
    logic [7:0]              power_q, power_d;
    logic [7:0]              death_q, death_d;
    logic [1:0]              combo_q, combo_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic [NUM_GHOSTS-1:0]   respawn_q, respawn_d;
    logic                    life_lost_q, life_lost_d;

    conv_e                   conv_q, conv_d;
    logic [SCORE_W-1:0]      bin_q, bin_d;
    logic [SCORE_W-1:0]      src_q, src_d;
    logic [4*DIGITS-1:0]     work_q, work_d;
    logic [4*DIGITS-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NUM_GHOSTS-1:0]   coll;
    logic [SUM_W-1:0]        add, sum;
    logic [9:0]              dots_new;
    logic [1:0]              k;
    logic [4*DIGITS-1:0]     adj;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_coll
        logic [COORD_W-1:0] gx, gy, dx, dy;
        assign gx = ghost_x[g*COORD_W +: COORD_W];
        assign gy = ghost_y[g*COORD_W +: COORD_W];
        assign dx = (gx >= player_x) ? gx - player_x : player_x - gx;
        assign dy = (gy >= player_y) ? gy - player_y : player_y - gy;
        assign coll[g] = (dx < TILE) && (dy < TILE);
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        dots_d      = dots_q;
        power_d     = power_q;
        death_d     = death_q;
        combo_d     = combo_q;
        score_d     = score_q;
        respawn_d   = '0;
        life_lost_d = 1'b0;
        add         = '0;
        sum         = '0;
        k           = combo_q;
        dots_new    = {1'b0, dots_q} + 10'(dot_hit) + 10'(bigdot_hit);

        case (state_q)
            ST_STANDBY: if (start) state_d = ST_PLAYING;
            ST_PLAYING, ST_POWER: if (tick) begin
                if (dot_hit)    add = add + SUM_W'(DOT_POINTS);
                if (bigdot_hit) add = add + SUM_W'(BIGDOT_POINTS);
                dots_d = dots_new[8:0];
                if (dots_new >= 10'(MAX_DOTS)) begin
                    state_d = ST_WIN;
                    power_d = '0;
                end else if (state_q == ST_PLAYING) begin
                    if (bigdot_hit) begin
                        state_d = ST_POWER;
                        power_d = 8'(POWER_TICKS);
                        combo_d = '0;
                    end else if (|coll) begin
                        lives_d     = lives_q - 3'd1;
                        life_lost_d = 1'b1;
                        respawn_d   = '1;
                        if (lives_q == 3'd1) begin
                            state_d = ST_GAMEOVER;
                        end else begin
                            state_d = ST_DYING;
                            death_d = 8'(DEATH_TICKS);
                        end
                    end
                end else begin
                    // combo index saturates at 3, capping the ghost value at GHOST_POINTS<<3
                    if (bigdot_hit) k = '0;
                    for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
                        if (coll[i]) begin
                            add          = add + (SUM_W'(GHOST_POINTS) << k);
                            respawn_d[i] = 1'b1;
                            if (k != 2'd3) k = k + 2'd1;
                        end
                    end
                    combo_d = k;
                    if (bigdot_hit) begin
                        power_d = 8'(POWER_TICKS);
                    end else if (power_q == 8'd1) begin
                        power_d = '0;
                        state_d = ST_PLAYING;
                    end else begin
                        power_d = power_q - 8'd1;
                    end
                end
                sum     = {{(SUM_W-SCORE_W){1'b0}}, score_q} + add;
                score_d = (sum > MAX_SCORE) ? MAX_SCORE[SCORE_W-1:0] : sum[SCORE_W-1:0];
            end
            ST_DYING: if (tick) begin
                if (death_q == 8'd1) begin
                    death_d = '0;
                    state_d = ST_PLAYING;
                end else begin
                    death_d = death_q - 8'd1;
                end
            end
            default: ;
        endcase
    end

    // src_q holds the value last captured; any difference while idle starts a (coalesced) conversion
    always_comb begin
        conv_d = conv_q;
        bin_d  = bin_q;
        src_d  = src_q;
        work_d = work_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        adj    = work_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        case (conv_q)
            CV_IDLE: if (score_q != src_q) begin
                conv_d = CV_SHIFT;
                bin_d  = score_q;
                src_d  = score_q;
                work_d = '0;
                cnt_d  = CNT_W'(SCORE_W);
            end
            CV_SHIFT: begin
                work_d = {adj[4*DIGITS-2:0], bin_q[SCORE_W-1]};
                bin_d  = {bin_q[SCORE_W-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) conv_d = CV_DONE;
            end
            default: begin
                bcd_d  = work_q;
                conv_d = CV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_STANDBY;
            lives_q     <= 3'(LIVES);
            dots_q      <= '0;
            power_q     <= '0;
            death_q     <= '0;
            combo_q     <= '0;
            score_q     <= '0;
            respawn_q   <= '0;
            life_lost_q <= 1'b0;
            conv_q      <= CV_IDLE;
            bin_q       <= '0;
            src_q       <= '0;
            work_q      <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            dots_q      <= dots_d;
            power_q     <= power_d;
            death_q     <= death_d;
            combo_q     <= combo_d;
            score_q     <= score_d;
            respawn_q   <= respawn_d;
            life_lost_q <= life_lost_d;
            conv_q      <= conv_d;
            bin_q       <= bin_d;
            src_q       <= src_d;
            work_q      <= work_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign game_state      = state_q;
    assign ghost_respawn   = respawn_q;
    assign life_lost       = life_lost_q;
    assign lives           = lives_q;
    assign dots_eaten      = dots_q;
    assign power_remaining = power_q;
    assign score           = score_q;
    assign score_bcd       = bcd_q;
endmodule
